// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder/subtractor with a
// valid/ready stream interface.
//   Stage 1 conditions operands (b' = sub ? ~b : b, c0 = cin ^ sub) and registers
//   the bit terms h/g/p together with per-group generate/propagate.
//   Stage 2 resolves group carry-ins from {Gk, Pk, c0}, ripples inside each group,
//   and registers sum/cout/ovf plus word-level P/G.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready   result beat handshake (sum, cout, ovf, P, G)
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             P,
  output logic             G
);

  localparam int unsigned NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_param_check
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
  end

  // Stage valids and advance conditions
  logic v1;
  logic v2;
  logic adv1;
  logic adv2;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  // Reset forces ready so upstream never sees a stall while the pipe is flushed.
  assign in_ready  = adv1 | reset;
  assign out_valid = v2;

  // Operand conditioning, bit terms and per-group lookahead
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic [NG-1:0]    gg_in;
  logic [NG-1:0]    gp_in;

  always_comb begin
    b_eff = sub ? ~b : b;
    g_in  = a & b_eff;
    p_in  = a | b_eff;
    gg_in = '0;
    gp_in = '1;
    for (int unsigned k = 0; k < NG; k++) begin
      for (int unsigned j = 0; j < GROUP; j++) begin
        gg_in[k] = g_in[k*GROUP+j] | (p_in[k*GROUP+j] & gg_in[k]);
        gp_in[k] = gp_in[k] & p_in[k*GROUP+j];
      end
    end
  end

  // Stage 1 registers
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] p_q;
  logic             c0_q;
  logic [NG-1:0]    gg_q;
  logic [NG-1:0]    gp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      h_q  <= '0;
      g_q  <= '0;
      p_q  <= '0;
      c0_q <= 1'b0;
      gg_q <= '0;
      gp_q <= '0;
    end else if (adv1) begin
      v1   <= in_valid;
      h_q  <= a ^ b_eff;
      g_q  <= g_in;
      p_q  <= p_in;
      c0_q <= cin ^ sub;
      gg_q <= gg_in;
      gp_q <= gp_in;
    end
  end

  // Group carry-ins, in-group carries and word generate (c0 excluded)
  logic [NG:0]    gc;
  logic [WIDTH:0] c;
  logic           gw;

  always_comb begin
    gc    = '0;
    c     = '0;
    gw    = 1'b0;
    gc[0] = c0_q;
    for (int unsigned k = 0; k < NG; k++) begin
      gc[k+1] = gg_q[k] | (gp_q[k] & gc[k]);
      gw      = gg_q[k] | (gp_q[k] & gw);
    end
    for (int unsigned k = 0; k < NG; k++) begin
      c[k*GROUP] = gc[k];
      for (int unsigned j = 0; j + 1 < GROUP; j++) begin
        c[k*GROUP+j+1] = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & c[k*GROUP+j]);
      end
    end
    c[WIDTH] = gc[NG];
  end

  // Stage 2 registers, held while the result is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      v2   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      P    <= 1'b0;
      G    <= 1'b0;
    end else if (adv2) begin
      v2   <= v1;
      sum  <= h_q ^ c[WIDTH-1:0];
      cout <= c[WIDTH];
      ovf  <= c[WIDTH] ^ c[WIDTH-1];
      P    <= &gp_q;
      G    <= gw;
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Testbench for cla_adder_pipe: two instances (GROUP = 8 and GROUP = 4) share
// one stimulus stream; results are checked against arithmetic reference values.
`timescale 1ns/1ps
module tb_cla_adder_pipe;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         pp;
    logic         gg;
  } res_t;

  typedef struct {
    res_t        r;
    int unsigned acc_cyc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;

  logic         in_ready8, out_valid8, cout8, ovf8, p8, g8;
  logic         in_ready4, out_valid4, cout4, ovf4, p4, g4;
  logic [W-1:0] sum8, sum4;
  res_t         o8, o4;

  assign o8 = {sum8, cout8, ovf8, p8, g8};
  assign o4 = {sum4, cout4, ovf4, p4, g4};

  int checks   = 0;
  int failures = 0;

  cla_adder_pipe #(.WIDTH(W), .GROUP(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .P(p8), .G(g8)
  );

  cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .P(p4), .G(g4)
  );

  // Reference: plain integer addition of a + b' + c0
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    logic [W-1:0] yb;
    logic [W:0]   t;
    logic [W:0]   t0;
    res_t         r;
    yb     = s ? ~y : y;
    t0     = {1'b0, x} + {1'b0, yb};
    t      = t0 + (W+1)'(ci ^ s);
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == yb[W-1]) && (t[W-1] != x[W-1]);
    r.pp   = &(x | yb);
    r.gg   = t0[W];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return W'($urandom());
    endcase
  endfunction

  // Stimulus only: offer one beat with out_ready=1, return both results and latency
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                      input logic s, output res_t r8, output res_t r4, output int lat);
    r8  = '0;
    r4  = '0;
    lat = -1;
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 20; i++) begin
      #2;
      if (out_valid8 === 1'b1) begin
        lat = i;
        r8  = o8;
        r4  = o4;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      checks++;
      if (out_valid8 !== 1'b0 || out_valid4 !== 1'b0 || o8 !== '0 || o4 !== '0 ||
          in_ready8 !== 1'b1 || in_ready4 !== 1'b1) begin
        failures++;
        $display("FAIL reset_state cyc=%0d: ov=%b/%b res=%h/%h rdy=%b/%b, expected ov=0 res=0 rdy=1",
                 i, out_valid8, out_valid4, o8, o4, in_ready8, in_ready4);
      end
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; a = 32'd9; b = 32'd4;
    #2;
    checks++;
    if (in_ready8 !== 1'b1 || in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_accept: rdy=%b/%b expected 1", in_ready8, in_ready4);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid8 !== 1'b0 || out_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_latency_early: ov=%b/%b expected 0", out_valid8, out_valid4);
    end
    @(negedge clk);
    #2;
    checks++;
    if (out_valid8 !== 1'b1 || out_valid4 !== 1'b1 || sum8 !== 32'd13 || sum4 !== 32'd13) begin
      failures++;
      $display("FAIL reset_first_result: ov=%b/%b sum=%h/%h expected ov=1 sum=d", out_valid8,
               out_valid4, sum8, sum4);
    end
  endtask

  task automatic test_wrap();
    res_t r8, r4, e;
    int   lat;
    e = {32'h0, 1'b1, 1'b0, 1'b1, 1'b1};
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, r8, r4, lat);
    checks++;
    if (lat != 2 || r8 !== e || r4 !== e) begin
      failures++;
      $display("FAIL wrap: lat=%0d res=%h/%h expected lat=2 res=%h", lat, r8, r4, e);
    end
  endtask

  task automatic test_subtract();
    res_t r8, r4, e;
    int   lat;
    e = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    send(32'd5, 32'd7, 1'b0, 1'b1, r8, r4, lat);
    checks++;
    if (lat != 2 || r8 !== e || r4 !== e) begin
      failures++;
      $display("FAIL sub_cin0: lat=%0d res=%h/%h expected lat=2 res=%h", lat, r8, r4, e);
    end
    e = {32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b0};
    send(32'd5, 32'd7, 1'b1, 1'b1, r8, r4, lat);
    checks++;
    if (lat != 2 || r8 !== e || r4 !== e) begin
      failures++;
      $display("FAIL sub_cin1: lat=%0d res=%h/%h expected lat=2 res=%h", lat, r8, r4, e);
    end
  endtask

  task automatic test_overflow();
    res_t r8, r4, e;
    int   lat;
    e = {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r8, r4, lat);
    checks++;
    if (lat != 2 || r8 !== e || r4 !== e) begin
      failures++;
      $display("FAIL ovf_pos: lat=%0d res=%h/%h expected lat=2 res=%h", lat, r8, r4, e);
    end
    e = {32'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, r8, r4, lat);
    checks++;
    if (lat != 2 || r8 !== e || r4 !== e) begin
      failures++;
      $display("FAIL ovf_neg: lat=%0d res=%h/%h expected lat=2 res=%h", lat, r8, r4, e);
    end
  endtask

  task automatic test_backpressure();
    int           acc;
    logic [W-1:0] beat;
    res_t         e1;
    logic [W-1:0] got8[$];
    logic [W-1:0] got4[$];
    acc  = 0;
    beat = 32'd1;
    e1   = {32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = (beat <= 32'd3); a = beat; b = '0; cin = 1'b0; sub = 1'b0;
      #2;
      if (cyc >= 2) begin
        checks++;
        if (in_ready8 !== 1'b0 || in_ready4 !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready cyc=%0d: rdy=%b/%b expected 0", cyc, in_ready8, in_ready4);
        end
        checks++;
        if (out_valid8 !== 1'b1 || out_valid4 !== 1'b1 || o8 !== e1 || o4 !== e1) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d: ov=%b/%b res=%h/%h expected ov=1 res=%h", cyc,
                   out_valid8, out_valid4, o8, o4, e1);
        end
      end
      if (in_valid && in_ready8) begin
        acc++;
        beat++;
      end
    end
    checks++;
    if (acc != 2) begin
      failures++;
      $display("FAIL bp_accept_count: accepted=%0d expected 2", acc);
    end
    for (int cyc = 0; cyc < 20 && (got8.size() < 3 || got4.size() < 3); cyc++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = (beat <= 32'd3); a = beat;
      #2;
      if (out_valid8 === 1'b1) got8.push_back(sum8);
      if (out_valid4 === 1'b1) got4.push_back(sum4);
      if (in_valid && in_ready8) beat++;
    end
    in_valid = 1'b0;
    checks++;
    if (got8.size() != 3 || got4.size() != 3) begin
      failures++;
      $display("FAIL bp_drain_count: got=%0d/%0d expected 3", got8.size(), got4.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got8[i] !== W'(i + 1) || got4[i] !== W'(i + 1)) begin
          failures++;
          $display("FAIL bp_order idx=%0d: sum=%h/%h expected %0d", i, got8[i], got4[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd100; b = 32'd1; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    a = 32'd200;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid8 !== 1'b1 || out_valid4 !== 1'b1 || in_ready8 !== 1'b0 || in_ready4 !== 1'b0) begin
      failures++;
      $display("FAIL mid_full: ov=%b/%b rdy=%b/%b expected ov=1 rdy=0", out_valid8, out_valid4,
               in_ready8, in_ready4);
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (in_ready8 !== 1'b1 || in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_ready: rdy=%b/%b expected 1", in_ready8, in_ready4);
    end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid8 !== 1'b0 || out_valid4 !== 1'b0 || o8 !== '0 || o4 !== '0) begin
      failures++;
      $display("FAIL mid_reset_clear: ov=%b/%b res=%h/%h expected 0", out_valid8, out_valid4, o8, o4);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      checks++;
      if (out_valid8 !== 1'b0 || out_valid4 !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale cyc=%0d: ov=%b/%b expected 0", i, out_valid8, out_valid4);
      end
    end
  endtask

  // Scoreboard: a beat is visible once two edges have passed since its accept
  // and all older beats have left; the pipe holds at most two beats.
  task automatic test_random();
    item_t       q[$];
    item_t       it;
    int unsigned cyc;
    int          accepted;
    logic        exp_valid;
    logic        exp_ready;
    cyc      = 0;
    accepted = 0;
    for (int n = 0; n < 60000 && (accepted < 10000 || q.size() > 0); n++) begin
      @(negedge clk);
      in_valid  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
      a         = rnd_op();
      b         = rnd_op();
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      exp_valid = (q.size() > 0) && ((cyc - q[0].acc_cyc) >= 2);
      exp_ready = (q.size() < 2) || out_ready;
      checks++;
      if (out_valid8 !== exp_valid || out_valid4 !== exp_valid) begin
        failures++;
        $display("FAIL rnd_out_valid cyc=%0d: ov=%b/%b expected %b", cyc, out_valid8, out_valid4,
                 exp_valid);
      end
      checks++;
      if (in_ready8 !== exp_ready || in_ready4 !== exp_ready) begin
        failures++;
        $display("FAIL rnd_in_ready cyc=%0d: rdy=%b/%b expected %b", cyc, in_ready8, in_ready4,
                 exp_ready);
      end
      if (exp_valid) begin
        checks++;
        if (o8 !== q[0].r || o4 !== q[0].r) begin
          failures++;
          $display("FAIL rnd_result cyc=%0d: res=%h/%h expected %h", cyc, o8, o4, q[0].r);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        it.r       = model(a, b, cin, sub);
        it.acc_cyc = cyc;
        q.push_back(it);
        accepted++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != 10000 || q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain: accepted=%0d pending=%0d expected 10000 and 0", accepted, q.size());
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_wrap();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
